// File: rtl/refill_ctrl_pkg.sv
// Shared definitions for the cache-line refill controller.
// Holds the default word/line geometry and the refill FSM state encodings.
package refill_ctrl_pkg;

    localparam int CPU_WORD            = 32;
    localparam int CPU_LINE_WORDS      = 4;
    localparam int CPU_ADDR_W          = 32;
    localparam int CACHE_LINE_WIDTH    = CPU_WORD * CPU_LINE_WORDS;
    localparam int CACHE_LINE_BYTE_LOG = $clog2(CACHE_LINE_WIDTH / 8);

    // Refill FSM encodings, kept as plain constants for legacy compatibility
    localparam logic [2:0] REFILL_IDLE  = 3'd0;
    localparam logic [2:0] REFILL_REQ   = 3'd1;
    localparam logic [2:0] REFILL_RECV  = 3'd2;
    localparam logic [2:0] REFILL_WRITE = 3'd3;
    localparam logic [2:0] REFILL_DONE  = 3'd4;

    // Width of an index over n items, never narrower than one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/refill_line_asm.sv
// Beat counter and line slot register for a refill burst.
// Each accepted beat lands in word slot [cnt]; clr restarts the line at slot 0.
module refill_line_asm
    import refill_ctrl_pkg::*;
#(
    parameter int WORD       = CPU_WORD,
    parameter int LINE_WORDS = CPU_LINE_WORDS,
    parameter int CW         = idx_w(LINE_WORDS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       ret_valid,
    input  logic [WORD-1:0]            ret_data,
    output logic [CW-1:0]              cnt,
    output logic [WORD*LINE_WORDS-1:0] line
);

    logic [CW-1:0]              r_cnt;
    logic [WORD*LINE_WORDS-1:0] r_line;

    // Slot write and count advance on every beat the controller passes through
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt  <= '0;
            r_line <= '0;
        end else if (ret_valid) begin
            r_line[r_cnt*WORD +: WORD] <= ret_data;
            r_cnt                      <= r_cnt + 1'b1;
        end
    end

    assign cnt  = r_cnt;
    assign line = r_line;

endmodule

// File: rtl/refill_ctrl.sv
// Cache-line refill sequencer: burst request, beat collection, one-cycle
// line write into the return buffer, completion pulse.
// Optional feature macro: CRITICAL_WORD_FWD_EN adds fwd_valid/fwd_data, which
// forward the missing word straight from its return beat.
module refill_ctrl
    import refill_ctrl_pkg::*;
#(
    parameter int WORD       = CPU_WORD,
    parameter int LINE_WORDS = CPU_LINE_WORDS,
    parameter int ADDR_W     = CPU_ADDR_W,
    parameter int CW         = idx_w(LINE_WORDS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       miss_valid,
    input  logic [ADDR_W-1:0]          miss_addr,
    output logic                       miss_ready,
    output logic                       rd_req,
    output logic [ADDR_W-1:0]          rd_addr,
    input  logic                       rd_rdy,
    input  logic                       ret_valid,
    input  logic                       ret_last,
    input  logic [WORD-1:0]            ret_data,
    output logic                       rb_we,
    output logic [WORD*LINE_WORDS-1:0] rb_line,
    output logic [CW-1:0]              rb_addr,
    output logic                       refill_done,
    output logic                       busy,
`ifdef CRITICAL_WORD_FWD_EN
    output logic                       fwd_valid,
    output logic [WORD-1:0]            fwd_data,
`endif
    output logic                       proto_err
);

    localparam int              WORD_BYTE_LOG = $clog2(WORD / 8);
    localparam int              LINE_BYTES    = WORD * LINE_WORDS / 8;
    localparam logic [ADDR_W-1:0] LINE_MASK   = ~ADDR_W'(LINE_BYTES - 1);
    localparam logic [CW-1:0]   LAST_IDX      = CW'(LINE_WORDS - 1);

    logic [2:0]                 r_state;
    logic [ADDR_W-1:0]          r_addr;
    logic [CW-1:0]              r_off;
    logic                       r_proto_err;
    logic                       w_beat;
    logic                       w_last_beat;
    logic [CW-1:0]              w_cnt;
    logic [WORD*LINE_WORDS-1:0] w_line;

    // Beats only count while receiving; stray beats elsewhere are dropped here
    assign w_beat      = ret_valid && (r_state == REFILL_RECV);
    assign w_last_beat = w_beat && (w_cnt == LAST_IDX);

    refill_line_asm #(
        .WORD       (WORD),
        .LINE_WORDS (LINE_WORDS),
        .CW         (CW)
    ) u_line_asm (
        .clk       (clk),
        .rst       (rst),
        .clr       (r_state == REFILL_IDLE),
        .ret_valid (w_beat),
        .ret_data  (ret_data),
        .cnt       (w_cnt),
        .line      (w_line)
    );

    // Refill sequencing; reset aborts from any state with no write or done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= REFILL_IDLE;
            r_addr  <= '0;
            r_off   <= '0;
        end else begin
            case (r_state)
                REFILL_IDLE: begin
                    if (miss_valid) begin
                        r_state <= REFILL_REQ;
                        r_addr  <= miss_addr;
                        r_off   <= miss_addr[WORD_BYTE_LOG +: CW];
                    end
                end
                REFILL_REQ: begin
                    if (rd_rdy) r_state <= REFILL_RECV;
                end
                REFILL_RECV: begin
                    if (w_last_beat) r_state <= REFILL_WRITE;
                end
                REFILL_WRITE: r_state <= REFILL_DONE;
                REFILL_DONE:  r_state <= REFILL_IDLE;
                default:      r_state <= REFILL_IDLE;
            endcase
        end
    end

    // Sticky flag: ret_last must mark exactly the final beat of the line
    always_ff @(posedge clk) begin
        if (rst) begin
            r_proto_err <= 1'b0;
        end else if (w_beat && (ret_last != (w_cnt == LAST_IDX))) begin
            r_proto_err <= 1'b1;
        end
    end

    // miss_ready is held low while reset is asserted so every output reads 0
    assign miss_ready  = (r_state == REFILL_IDLE) && !rst;
    assign rd_req      = (r_state == REFILL_REQ);
    assign rd_addr     = r_addr & LINE_MASK;
    assign rb_we       = (r_state == REFILL_WRITE);
    assign rb_line     = w_line;
    assign rb_addr     = r_off;
    assign refill_done = (r_state == REFILL_DONE);
    assign busy        = (r_state != REFILL_IDLE);
    assign proto_err   = r_proto_err;

`ifdef CRITICAL_WORD_FWD_EN
    // Forward the critical word combinationally on the beat that carries it
    assign fwd_valid = w_beat && (w_cnt == r_off);
    assign fwd_data  = ret_data;
`endif

endmodule

// File: tb/tb_refill_ctrl.sv
// Scoreboard bench for refill_ctrl: stimulus pushes expected burst addresses
// and return-buffer writes; a negedge monitor pops and compares them.
module tb_refill_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         miss_valid;
    logic [31:0]  miss_addr;
    logic         miss_ready;
    logic         rd_req;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_valid;
    logic         ret_last;
    logic [31:0]  ret_data;
    logic         rb_we;
    logic [127:0] rb_line;
    logic [1:0]   rb_addr;
    logic         refill_done;
    logic         busy;
    logic         proto_err;
`ifdef CRITICAL_WORD_FWD_EN
    logic         fwd_valid;
    logic [31:0]  fwd_data;
`endif

    typedef struct packed {
        logic [127:0] line;
        logic [1:0]   off;
    } rb_exp_t;

    rb_exp_t     rbq[$];
    logic [31:0] rdq[$];
    int          checks = 0;
    int          errors = 0;

    localparam logic [127:0] LINE_A = {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};
    localparam logic [127:0] LINE_B = {32'hB3B3_1003, 32'hB2B2_1002, 32'hB1B1_1001, 32'hB0B0_1000};
    localparam logic [127:0] LINE_C = {32'hC3C3_2003, 32'hC2C2_2002, 32'hC1C1_2001, 32'hC0C0_2000};
    localparam logic [127:0] LINE_D = {32'hD3D3_3003, 32'hD2D2_3002, 32'hD1D1_3001, 32'hD0D0_3000};
    localparam logic [127:0] LINE_E = {32'hE3E3_4003, 32'hE2E2_4002, 32'hE1E1_4001, 32'hE0E0_4000};

    refill_ctrl u_dut (
        .clk         (clk),
        .rst         (rst),
        .miss_valid  (miss_valid),
        .miss_addr   (miss_addr),
        .miss_ready  (miss_ready),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_rdy      (rd_rdy),
        .ret_valid   (ret_valid),
        .ret_last    (ret_last),
        .ret_data    (ret_data),
        .rb_we       (rb_we),
        .rb_line     (rb_line),
        .rb_addr     (rb_addr),
        .refill_done (refill_done),
        .busy        (busy),
`ifdef CRITICAL_WORD_FWD_EN
        .fwd_valid   (fwd_valid),
        .fwd_data    (fwd_data),
`endif
        .proto_err   (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Monitor: burst address, return-buffer write and done-pulse ordering
    logic        prev_rd_req = 1'b0;
    logic        prev_we     = 1'b0;
    logic [31:0] cur_rd_exp  = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_rd_req = 1'b0;
            prev_we     = 1'b0;
        end else begin
            if (rd_req) begin
                if (!prev_rd_req) begin
                    if (rdq.size() == 0) chk("rd_req_unexpected", 1, 0);
                    else cur_rd_exp = rdq.pop_front();
                end
                chk("rd_addr", rd_addr, cur_rd_exp);
            end
            if (rb_we) begin
                if (rbq.size() == 0) begin
                    chk("rb_we_unexpected", 1, 0);
                end else begin
                    rb_exp_t e;
                    e = rbq.pop_front();
                    chk("rb_line", rb_line, e.line);
                    chk("rb_addr", rb_addr, e.off);
                end
            end
            if (refill_done && !prev_we) chk("done_without_we", 1, 0);
            if (prev_we) chk("done_after_we", refill_done, 1);
            prev_rd_req = rd_req;
            prev_we     = rb_we;
        end
    end

    task automatic expect_refill(input logic [31:0] rda, input logic [127:0] line,
                                 input logic [1:0] off, input logic writes);
        rb_exp_t e;
        rdq.push_back(rda);
        if (writes) begin
            e.line = line;
            e.off  = off;
            rbq.push_back(e);
        end
    endtask

    task automatic issue_miss(input logic [31:0] addr);
        chk("miss_ready_idle", miss_ready, 1);
        miss_addr  = addr;
        miss_valid = 1'b1;
        @(posedge clk); #1;
        miss_valid = 1'b0;
    endtask

    task automatic give_rdy(input int dly);
        repeat (dly) begin @(posedge clk); #1; end
        rd_rdy = 1'b1;
        @(posedge clk); #1;
        rd_rdy = 1'b0;
    endtask

    task automatic give_beats(input logic [127:0] line, input int n, input int gap,
                              input int last_idx, input int off);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                ret_data = 32'hDEAD_BEEF;
                @(posedge clk); #1;
            end
            ret_valid = 1'b1;
            ret_data  = line[i*32 +: 32];
            ret_last  = (i == last_idx);
`ifdef CRITICAL_WORD_FWD_EN
            #1;
            chk("fwd_valid", fwd_valid, (i == off));
            if (i == off) chk("fwd_data", fwd_data, line[i*32 +: 32]);
`else
            if (off < 0) chk("beat_off", 0, 1);
`endif
            @(posedge clk); #1;
            ret_valid = 1'b0;
            ret_last  = 1'b0;
        end
    endtask

    // Leaves the caller at the negedge of the DONE cycle
    task automatic wait_done();
        logic seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (refill_done) seen = 1'b1;
        end
        chk("done_seen", seen, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        miss_valid = 1'b0;
        miss_addr  = '0;
        rd_rdy     = 1'b0;
        ret_valid  = 1'b0;
        ret_last   = 1'b0;
        ret_data   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {miss_ready, rd_req, rd_addr, rb_we, rb_line, rb_addr,
                            refill_done, busy, proto_err}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", miss_ready, 1);
        chk("post_rst_busy", busy, 0);
        @(posedge clk); #1;

        // 1: basic refill of word 3 in line 0x10
        expect_refill(32'h10, LINE_A, 2'd3, 1'b1);
        issue_miss(32'h1C);
        chk("busy_req", busy, 1);
        give_rdy(2);
        give_beats(LINE_A, 4, 0, 3, 3);
        wait_done();
        chk("proto_clean", proto_err, 0);
        @(posedge clk); #1;

        // 2: gapped beats produce the same line
        expect_refill(32'h10, LINE_A, 2'd3, 1'b1);
        issue_miss(32'h1C);
        give_rdy(0);
        give_beats(LINE_A, 4, 2, 3, 3);
        wait_done();
        @(posedge clk); #1;

        // 3: early ret_last sets a sticky error, refill still finishes
        expect_refill(32'h20, LINE_B, 2'd0, 1'b1);
        issue_miss(32'h20);
        give_rdy(1);
        give_beats(LINE_B, 4, 0, 1, 0);
        wait_done();
        chk("proto_set", proto_err, 1);
        @(posedge clk); #1;
        expect_refill(32'h30, LINE_C, 2'd2, 1'b1);
        issue_miss(32'h38);
        give_rdy(0);
        give_beats(LINE_C, 4, 0, 3, 2);
        wait_done();
        chk("proto_sticky", proto_err, 1);
        @(posedge clk); #1;

        // 4: reset mid-burst, then stray beats, then a clean refill
        expect_refill(32'h50, LINE_D, 2'd0, 1'b0);
        issue_miss(32'h50);
        give_rdy(0);
        give_beats(LINE_D, 2, 0, 9, 9);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_ready", miss_ready, 1);
        chk("abort_proto", proto_err, 0);
        chk("abort_rdreq", rd_req, 0);
        @(posedge clk); #1;
        ret_valid = 1'b1; ret_last = 1'b1; ret_data = 32'h5555_AAAA;
        repeat (2) begin @(posedge clk); #1; end
        ret_valid = 1'b0; ret_last = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("stray_busy", busy, 0);
        expect_refill(32'h60, LINE_D, 2'd1, 1'b1);
        issue_miss(32'h64);
        give_rdy(0);
        give_beats(LINE_D, 4, 0, 3, 1);
        wait_done();
        @(posedge clk); #1;

        // 5: miss_valid held high across two refills
        expect_refill(32'h40, LINE_E, 2'd0, 1'b1);
        expect_refill(32'h80, LINE_A, 2'd1, 1'b1);
        miss_addr  = 32'h40;
        miss_valid = 1'b1;
        @(posedge clk); #1;
        miss_addr = 32'h84;
        @(negedge clk);
        chk("b2b_ready_busy", miss_ready, 0);
        chk("b2b_busy", busy, 1);
        give_rdy(0);
        give_beats(LINE_E, 4, 0, 3, 0);
        wait_done();
        chk("b2b_ready_done", miss_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b_ready_idle", miss_ready, 1);
        @(posedge clk); #1;
        miss_valid = 1'b0;
        chk("b2b_second_accept", busy, 1);
        give_rdy(1);
        give_beats(LINE_A, 4, 0, 3, 1);
        wait_done();
        @(posedge clk); #1;

`ifdef CRITICAL_WORD_FWD_EN
        // 6: critical word forwarded on beat 2 only
        expect_refill(32'h10, LINE_A, 2'd2, 1'b1);
        issue_miss(32'h18);
        give_rdy(0);
        give_beats(LINE_A, 4, 0, 3, 2);
        wait_done();
        @(posedge clk); #1;
`endif

        repeat (3) begin @(posedge clk); #1; end
        chk("rbq_drained", rbq.size(), 0);
        chk("rdq_drained", rdq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
